// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain: parameterised chain of STAGES pipeline registers using the
// valid / allowin / ready_go handshake of the CPU stage modules. Each stage can
// stall through its ready_go bit and can be flushed independently. The valid bit
// and payload of every stage are exported as forwarding taps.
//
// Parameters:
//   DATA_W  payload width per stage
//   STAGES  number of register stages (>= 1)
//   CNT_W   width of the occupancy output
//
// Ports:
//   clk, resetn     clock and asynchronous active-low reset
//   in_valid        upstream offers in_data
//   in_data         upstream payload
//   in_allowin      chain accepts a payload this cycle (allowin of stage 0)
//   stage_ready_go  per-stage "work done, may advance"
//   flush           per-stage kill of the stage's content
//   out_valid       last stage offers out_data
//   out_data        last stage payload
//   out_allowin     downstream accepts
//   stage_valid     valid bit of each stage
//   stage_data      payload of each stage, stage i at [i*DATA_W +: DATA_W]
//   occupancy       number of valid stages
//   stall_cnt       saturating count of stall cycles
//
// Optional feature: define PIPE_STALL_CNT_EN to build the stall-cycle counter.
// Without it, stall_cnt is tied to zero and no counter logic is built.

module pipe_stage_chain #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STAGES = 5,
  parameter int unsigned CNT_W  = $clog2(STAGES + 1)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     in_allowin,
  input  logic [STAGES-1:0]        stage_ready_go,
  input  logic [STAGES-1:0]        flush,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  input  logic                     out_allowin,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*DATA_W-1:0] stage_data,
  output logic [CNT_W-1:0]         occupancy,
  output logic [31:0]              stall_cnt
);

  logic [STAGES-1:0]             valid_q, valid_d;
  logic [STAGES-1:0][DATA_W-1:0] data_q, data_d;

  logic [STAGES-1:0]             go;       // stage i hands its payload on
  logic [STAGES-1:0]             allowin;  // stage i can take a payload
  logic [STAGES-1:0]             up_go;    // go of the stage feeding stage i
  logic [STAGES-1:0][DATA_W-1:0] up_data;  // payload of the stage feeding stage i

  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      go[i] = valid_q[i] & stage_ready_go[i] & ~flush[i];
    end
  end

  // The allowin ripple runs from the output back to the input. A scalar carries
  // the downstream term so the vector is only written, never read, in this block.
  always_comb begin
    logic a;
    a = out_allowin;
    for (int i = STAGES - 1; i >= 0; i--) begin
      a          = ~valid_q[i] | (stage_ready_go[i] & a);
      allowin[i] = a;
    end
  end

  always_comb begin
    up_go[0]   = in_valid;
    up_data[0] = in_data;
    for (int i = 1; i < STAGES; i++) begin
      up_go[i]   = go[i-1];
      up_data[i] = data_q[i-1];
    end
  end

  // Flush wins over capture: the incoming payload is dropped, but the upstream
  // stage still sees allowin and retires its content.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    for (int i = 0; i < STAGES; i++) begin
      if (flush[i]) begin
        valid_d[i] = 1'b0;
      end else if (allowin[i]) begin
        valid_d[i] = up_go[i];
        if (up_go[i]) begin
          data_d[i] = up_data[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < STAGES; i++) begin
      occupancy = occupancy + CNT_W'(valid_q[i]);
    end
  end

  assign in_allowin  = allowin[0];
  assign out_valid   = go[STAGES-1];
  assign out_data    = data_q[STAGES-1];
  assign stage_valid = valid_q;
  assign stage_data  = data_q;

`ifdef PIPE_STALL_CNT_EN
  logic [31:0] stall_q;
  logic        stall_any;

  // A valid stage with allowin low is exactly "valid and (not ready_go or
  // downstream not allowing in)", so the allowin vector serves directly.
  assign stall_any = |(valid_q & ~allowin);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stall_q <= '0;
    end else if (stall_any && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed self-checking bench for pipe_stage_chain (STAGES=5, DATA_W=32).
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_pipe_stage_chain;

  localparam int unsigned DW = 32;
  localparam int unsigned NS = 5;

`ifdef PIPE_STALL_CNT_EN
  localparam bit StallEn = 1'b1;
`else
  localparam bit StallEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             resetn;
  logic             in_valid;
  logic [DW-1:0]    in_data;
  logic             in_allowin;
  logic [NS-1:0]    stage_ready_go;
  logic [NS-1:0]    flush;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic             out_allowin;
  logic [NS-1:0]    stage_valid;
  logic [NS*DW-1:0] stage_data;
  logic [2:0]       occupancy;
  logic [31:0]      stall_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pipe_stage_chain #(.DATA_W(DW), .STAGES(NS)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_allowin    (in_allowin),
    .stage_ready_go(stage_ready_go),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_allowin   (out_allowin),
    .stage_valid   (stage_valid),
    .stage_data    (stage_data),
    .occupancy     (occupancy),
    .stall_cnt     (stall_cnt)
  );

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; in_valid = 1'b0; in_data = '0;
    stage_ready_go = '1; flush = '0; out_allowin = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Five consecutive accepts into an empty chain; base ends in stage 4.
  task automatic fill(input int base);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid = 1'b1; in_data = DW'(base + k);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0; in_valid = 1'b1; in_data = 32'hAA;
    stage_ready_go = '1; flush = '0; out_allowin = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
    checks++; if (stage_valid !== 5'b00000) begin failures++; $display("FAIL rst_stage_valid got=%b exp=00000", stage_valid); end
    checks++; if (occupancy !== 3'd0) begin failures++; $display("FAIL rst_occupancy got=%0d exp=0", occupancy); end
    checks++; if (in_allowin !== 1'b1) begin failures++; $display("FAIL rst_in_allowin got=%b exp=1", in_allowin); end
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL rst_stall_cnt got=%0d exp=0", stall_cnt); end
    @(negedge clk); #1;
    checks++; if (stage_valid !== 5'b00000) begin failures++; $display("FAIL rst_held got=%b exp=00000", stage_valid); end
    resetn = 1'b1;
    @(negedge clk); #1;
    checks++; if (stage_valid !== 5'b00001) begin failures++; $display("FAIL rst_first_accept got=%b exp=00001", stage_valid); end
    checks++; if (stage_data[31:0] !== 32'hAA) begin failures++; $display("FAIL rst_first_data got=%h exp=000000aa", stage_data[31:0]); end
  endtask

  task automatic test_streaming();
    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      in_valid = (c < 10); in_data = DW'(c);
      #1;
      checks++;
      if (out_valid !== ((c >= 5) && (c < 15))) begin
        failures++; $display("FAIL stream_valid c=%0d got=%b exp=%b", c, out_valid, (c >= 5) && (c < 15));
      end
      if ((c >= 5) && (c < 15)) begin
        checks++;
        if (out_data !== DW'(c - 5)) begin
          failures++; $display("FAIL stream_data c=%0d got=%0d exp=%0d", c, out_data, c - 5);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int nxt, got, cyc;
    do_reset();
    out_allowin = 1'b0;
    fill(0);
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'd5;
    #1;
    checks++; if (in_allowin !== 1'b0) begin failures++; $display("FAIL bp_in_allowin got=%b exp=0", in_allowin); end
    checks++; if (occupancy !== 3'd5) begin failures++; $display("FAIL bp_occupancy got=%0d exp=5", occupancy); end
    @(negedge clk); #1;
    checks++; if (stage_valid !== 5'b11111) begin failures++; $display("FAIL bp_hold got=%b exp=11111", stage_valid); end
    nxt = 5; got = 0; cyc = 0;
    out_allowin = 1'b1;
    while (got < 7 && cyc < 30) begin
      in_valid = (nxt < 7); in_data = DW'(nxt);
      #1;
      if (out_valid) begin
        checks++;
        if (out_data !== DW'(got)) begin failures++; $display("FAIL bp_order got=%0d exp=%0d", out_data, got); end
        got++;
      end
      if (in_valid && in_allowin) nxt++;
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (got != 7) begin failures++; $display("FAIL bp_count got=%0d exp=7", got); end
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
  endtask

  task automatic test_bubble();
    do_reset();
    out_allowin = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h77;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks++; if (stage_valid !== 5'b10000) begin failures++; $display("FAIL bubble_pos got=%b exp=10000", stage_valid); end
    checks++; if (in_allowin !== 1'b1) begin failures++; $display("FAIL bubble_allowin got=%b exp=1", in_allowin); end
  endtask

  task automatic test_mid_stall();
    int got;
    do_reset();
    out_allowin = 1'b0;
    fill(20);
    got = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      in_valid = 1'b0; out_allowin = 1'b1;
      stage_ready_go = (k < 3) ? 5'b11011 : 5'b11111;
      #1;
      if (k == 2) begin
        checks++; if (stage_valid !== 5'b00111) begin failures++; $display("FAIL stall_valid got=%b exp=00111", stage_valid); end
        checks++; if (in_allowin !== 1'b0) begin failures++; $display("FAIL stall_allowin got=%b exp=0", in_allowin); end
      end
      if (out_valid) begin
        checks++;
        if (out_data !== DW'(20 + got)) begin failures++; $display("FAIL stall_order got=%0d exp=%0d", out_data, 20 + got); end
        got++;
      end
    end
    checks++; if (got != 5) begin failures++; $display("FAIL stall_count got=%0d exp=5", got); end
  endtask

  task automatic test_flush();
    do_reset();
    out_allowin = 1'b0;
    fill(10);
    @(negedge clk);
    in_valid = 1'b0; out_allowin = 1'b1; flush = 5'b00111;
    #1;
    checks++; if (out_data !== 32'd10) begin failures++; $display("FAIL flush_retire got=%0d exp=10", out_data); end
    @(negedge clk);
    flush = '0;
    #1;
    checks++; if (stage_valid !== 5'b10000) begin failures++; $display("FAIL flush_valid got=%b exp=10000", stage_valid); end
    checks++; if (stage_data[4*DW +: DW] !== 32'd11) begin failures++; $display("FAIL flush_s4 got=%0d exp=11", stage_data[4*DW +: DW]); end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_leak k=%0d data=%0d", k, out_data); end
    end
    // flush[0] with in_valid: accepted and dropped.
    @(negedge clk);
    in_valid = 1'b1; in_data = 32'h55; flush = 5'b00001;
    #1;
    checks++; if (in_allowin !== 1'b1) begin failures++; $display("FAIL flush_in_allowin got=%b exp=1", in_allowin); end
    @(negedge clk);
    in_valid = 1'b0; flush = '0;
    #1;
    checks++; if (stage_valid !== 5'b00000) begin failures++; $display("FAIL flush_in_drop got=%b exp=00000", stage_valid); end
  endtask

  task automatic test_stall_cnt();
    do_reset();
    out_allowin = 1'b0;
    fill(0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL scnt_fill got=%0d exp=0", stall_cnt); end
    repeat (7) @(negedge clk);
    #1;
    checks++;
    if (stall_cnt !== (StallEn ? 32'd7 : 32'd0)) begin
      failures++; $display("FAIL scnt_seven got=%0d exp=%0d", stall_cnt, StallEn ? 7 : 0);
    end
    #2;
    resetn = 1'b0;
    #1;
    checks++; if (stall_cnt !== 32'd0) begin failures++; $display("FAIL scnt_reset got=%0d exp=0", stall_cnt); end
    checks++; if (stage_valid !== 5'b00000) begin failures++; $display("FAIL scnt_reset_valid got=%b exp=00000", stage_valid); end
    checks++; if (in_allowin !== 1'b1) begin failures++; $display("FAIL scnt_reset_allowin got=%b exp=1", in_allowin); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; in_valid = 1'b0; in_data = '0;
    stage_ready_go = '1; flush = '0; out_allowin = 1'b1;
    test_reset();
    test_streaming();
    test_backpressure();
    test_bubble();
    test_mid_stall();
    test_flush();
    test_stall_cnt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
